// File: rtl/pipe_stage_buf.sv
// pipe_stage_buf: elastic valid/ready pipeline register for the CPU32
// decode -> execute/memory/writeback boundary.
//
// Holds up to two beats: a main entry that drives the outputs and a skid
// entry that catches the beat arriving in the cycle the downstream stalls.
// Upstream ready is a pure flop output, so there is no combinational path
// from out_ready to in_ready.
//
// Optional build macro: PIPE_STAGE_PERF_CNT_EN adds the stall_cnt and
// bubble_cnt performance counter outputs.
//
// Handshake: a beat moves on a rising clk edge when valid and ready are both
// high on that edge (in_valid & in_ready upstream, out_valid & out_ready
// downstream). A producer holding valid keeps its payload stable until it is
// taken; ready never depends combinationally on valid.
module pipe_stage_buf #(
    parameter int                 WIDTH     = 96,
    parameter int                 SB_WIDTH  = 1,
    parameter logic [WIDTH-1:0]   NOP_VALUE = {WIDTH{1'b0}}
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic                in_pass,
    input  logic [WIDTH-1:0]    in_data,
    input  logic [SB_WIDTH-1:0] in_sb,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [WIDTH-1:0]    out_data,
    output logic [SB_WIDTH-1:0] out_sb,
    input  logic                flush,
`ifdef PIPE_STAGE_PERF_CNT_EN
    output logic [31:0]         stall_cnt,
    output logic [31:0]         bubble_cnt,
`endif
    output logic [1:0]          dbg_state
);

    // State encoding is {main valid, skid valid}; 2'b01 is unreachable.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_ONE   = 2'b10,
        ST_TWO   = 2'b11
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic                  r_in_ready;

    logic [WIDTH-1:0]      r_m_d;
    logic [SB_WIDTH-1:0]   r_m_sb;
    logic [WIDTH-1:0]      r_s_d;
    logic [SB_WIDTH-1:0]   r_s_sb;

    logic                  w_m_v;
    logic                  w_s_v;
    logic                  w_accept;
    logic                  w_drain;
    logic [WIDTH-1:0]      w_in_payload;

    // Per-cycle datapath controls produced by the FSM.
    logic                  w_ld_m_in;
    logic                  w_ld_m_skid;
    logic                  w_ld_s_in;
    logic                  w_clr_m;
    logic                  w_clr_s;

    assign w_m_v        = (r_state != ST_EMPTY);
    assign w_s_v        = (r_state == ST_TWO);
    assign w_accept     = in_valid & r_in_ready;
    assign w_drain      = w_m_v & out_ready;
    // Substitution happens on entry so the stored beat is already final.
    assign w_in_payload = in_pass ? in_data : NOP_VALUE;

    // State register and registered upstream ready (ready = skid empty).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_EMPTY;
            r_in_ready <= 1'b1;
        end else begin
            r_state    <= w_state_nxt;
            r_in_ready <= (w_state_nxt != ST_TWO);
        end
    end

    // Next state and datapath controls; flush overrides every transition.
    always_comb begin
        w_state_nxt = r_state;
        w_ld_m_in   = 1'b0;
        w_ld_m_skid = 1'b0;
        w_ld_s_in   = 1'b0;
        w_clr_m     = 1'b0;
        w_clr_s     = 1'b0;
        if (flush) begin
            w_state_nxt = ST_EMPTY;
            w_clr_m     = 1'b1;
            w_clr_s     = 1'b1;
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    if (w_accept) begin
                        w_state_nxt = ST_ONE;
                        w_ld_m_in   = 1'b1;
                    end
                end
                ST_ONE: begin
                    if (w_accept && w_drain) begin
                        w_ld_m_in   = 1'b1;
                    end else if (w_accept) begin
                        w_state_nxt = ST_TWO;
                        w_ld_s_in   = 1'b1;
                    end else if (w_drain) begin
                        w_state_nxt = ST_EMPTY;
                        w_clr_m     = 1'b1;
                    end
                end
                ST_TWO: begin
                    // in_ready is low here, so only a drain can happen.
                    if (w_drain) begin
                        w_state_nxt = ST_ONE;
                        w_ld_m_skid = 1'b1;
                        w_clr_s     = 1'b1;
                    end
                end
                default: begin
                    w_state_nxt = ST_EMPTY;
                    w_clr_m     = 1'b1;
                    w_clr_s     = 1'b1;
                end
            endcase
        end
    end

    // Main entry payload/sideband: load from input, from skid, or clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_m_d  <= NOP_VALUE;
            r_m_sb <= '0;
        end else if (w_clr_m) begin
            r_m_d  <= NOP_VALUE;
            r_m_sb <= '0;
        end else if (w_ld_m_in) begin
            r_m_d  <= w_in_payload;
            r_m_sb <= in_sb;
        end else if (w_ld_m_skid) begin
            r_m_d  <= r_s_d;
            r_m_sb <= r_s_sb;
        end
    end

    // Skid entry payload/sideband: catch the beat taken during a stall.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s_d  <= NOP_VALUE;
            r_s_sb <= '0;
        end else if (w_clr_s) begin
            r_s_d  <= NOP_VALUE;
            r_s_sb <= '0;
        end else if (w_ld_s_in) begin
            r_s_d  <= w_in_payload;
            r_s_sb <= in_sb;
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = w_m_v;
    assign out_data  = w_m_v ? r_m_d  : NOP_VALUE;
    assign out_sb    = w_m_v ? r_m_sb : '0;
    assign dbg_state = r_state;

`ifdef PIPE_STAGE_PERF_CNT_EN
    // Per-entry "was NOP-substituted" flags follow their beats.
    logic        r_m_nop;
    logic        r_s_nop;
    logic [31:0] r_stall_cnt;
    logic [31:0] r_bubble_cnt;

    // NOP flags move with the payload through main and skid.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_m_nop <= 1'b0;
            r_s_nop <= 1'b0;
        end else begin
            if (w_clr_m) begin
                r_m_nop <= 1'b0;
            end else if (w_ld_m_in) begin
                r_m_nop <= ~in_pass;
            end else if (w_ld_m_skid) begin
                r_m_nop <= r_s_nop;
            end
            if (w_clr_s) begin
                r_s_nop <= 1'b0;
            end else if (w_ld_s_in) begin
                r_s_nop <= ~in_pass;
            end
        end
    end

    // Free-running wrap-around counters; only rst clears them.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stall_cnt  <= 32'd0;
            r_bubble_cnt <= 32'd0;
        end else begin
            if (w_m_v && !out_ready) begin
                r_stall_cnt <= r_stall_cnt + 32'd1;
            end
            if (!w_m_v || (w_drain && r_m_nop)) begin
                r_bubble_cnt <= r_bubble_cnt + 32'd1;
            end
        end
    end

    assign stall_cnt  = r_stall_cnt;
    assign bubble_cnt = r_bubble_cnt;
`endif

endmodule

// File: tb/tb_pipe_stage_buf.sv
// tb_pipe_stage_buf: directed and randomized checks of pipe_stage_buf against
// a queue model of the held beats (oldest beat at the head).
module tb_pipe_stage_buf;
  localparam int W = 96;
  localparam int SB = 2;
  localparam logic [W-1:0] NOP = 96'h0BAD_F00D_0000_0000_5A5A_C3C3;

  // clock/reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic          in_valid = 1'b0;
  logic          in_ready;
  logic          in_pass = 1'b1;
  logic [W-1:0]  in_data = '0;
  logic [SB-1:0] in_sb = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [W-1:0]  out_data;
  logic [SB-1:0] out_sb;
  logic          flush = 1'b0;
  logic [1:0]    dbg_state;
`ifdef PIPE_STAGE_PERF_CNT_EN
  logic [31:0]   stall_cnt;
  logic [31:0]   bubble_cnt;
`endif

  pipe_stage_buf #(.WIDTH(W), .SB_WIDTH(SB), .NOP_VALUE(NOP)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_pass(in_pass),
    .in_data(in_data), .in_sb(in_sb),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_sb(out_sb), .flush(flush),
`ifdef PIPE_STAGE_PERF_CNT_EN
    .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt),
`endif
    .dbg_state(dbg_state)
  );

  // scoreboard: expected held beats {sb, payload} plus their NOP flags
  logic [W+SB-1:0] exp_q[$];
  bit              nop_q[$];
  int              m_stall = 0;
  int              m_bubble = 0;
  int              n_checks = 0;
  int              n_pass = 0;

  // driver: present inputs for one cycle, advance the model over the edge,
  // return #1 after the edge
  task automatic drive_cycle(input logic v, input logic pass, input logic [W-1:0] d,
                             input logic [SB-1:0] sb, input logic ordy, input logic flsh);
    bit acc, drn;
    in_valid = v; in_pass = pass; in_data = d; in_sb = sb;
    out_ready = ordy; flush = flsh;
    acc = v && (exp_q.size() < 2);
    drn = ordy && (exp_q.size() > 0);
    if (exp_q.size() == 0) m_bubble++;
    else if (drn && nop_q[0]) m_bubble++;
    if (exp_q.size() > 0 && !ordy) m_stall++;
    @(posedge clk);
    #1;
    if (flsh) begin
      exp_q.delete();
      nop_q.delete();
    end else begin
      if (drn) begin
        void'(exp_q.pop_front());
        void'(nop_q.pop_front());
      end
      if (acc) begin
        exp_q.push_back({sb, pass ? d : NOP});
        nop_q.push_back(!pass);
      end
    end
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    n_checks++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b exp 1", in_ready); else n_pass++;
    n_checks++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b exp 0", out_valid); else n_pass++;
    n_checks++; if (out_data !== NOP) $display("FAIL reset_out_data: got %h exp %h", out_data, NOP); else n_pass++;
    n_checks++; if (out_sb !== 2'b00) $display("FAIL reset_out_sb: got %b exp 00", out_sb); else n_pass++;
    n_checks++; if (dbg_state !== 2'b00) $display("FAIL reset_state: got %b exp 00", dbg_state); else n_pass++;
    rst = 1'b0;
    drive_cycle(1'b1, 1'b1, 96'h77, 2'b10, 1'b0, 1'b0);
    n_checks++; if (out_valid !== 1'b1 || out_data !== 96'h77) $display("FAIL reset_preload: got v=%b d=%h exp v=1 d=77", out_valid, out_data); else n_pass++;
    // async reset mid-cycle, observed before the next edge
    #3 rst = 1'b1;
    #1;
    n_checks++; if (out_valid !== 1'b0) $display("FAIL async_rst_valid: got %b exp 0", out_valid); else n_pass++;
    n_checks++; if (out_data !== NOP) $display("FAIL async_rst_data: got %h exp %h", out_data, NOP); else n_pass++;
    n_checks++; if (in_ready !== 1'b1) $display("FAIL async_rst_in_ready: got %b exp 1", in_ready); else n_pass++;
    n_checks++; if (out_sb !== 2'b00) $display("FAIL async_rst_sb: got %b exp 00", out_sb); else n_pass++;
`ifdef PIPE_STAGE_PERF_CNT_EN
    n_checks++; if (stall_cnt !== 32'd0 || bubble_cnt !== 32'd0) $display("FAIL async_rst_cnt: got %0d/%0d exp 0/0", stall_cnt, bubble_cnt); else n_pass++;
`endif
    exp_q.delete(); nop_q.delete(); m_stall = 0; m_bubble = 0;
    #1 rst = 1'b0;
  endtask

  task automatic test_streaming();
    logic [W-1:0] beats[3];
    beats[0] = 96'h11; beats[1] = 96'h22; beats[2] = 96'h33;
    for (int i = 0; i < 3; i++) begin
      drive_cycle(1'b1, 1'b1, beats[i], 2'(i), 1'b1, 1'b0);
      n_checks++; if (out_valid !== 1'b1 || out_data !== beats[i]) $display("FAIL stream_out_%0d: got v=%b d=%h exp v=1 d=%h", i, out_valid, out_data, beats[i]); else n_pass++;
      n_checks++; if (in_ready !== 1'b1) $display("FAIL stream_in_ready_%0d: got %b exp 1", i, in_ready); else n_pass++;
    end
    drive_cycle(1'b0, 1'b1, 'x, 2'b00, 1'b1, 1'b0);
    n_checks++; if (out_valid !== 1'b0 || out_data !== NOP) $display("FAIL stream_drained: got v=%b d=%h exp v=0 d=%h", out_valid, out_data, NOP); else n_pass++;
  endtask

  task automatic test_backpressure();
    drive_cycle(1'b1, 1'b1, 96'hA, 2'b01, 1'b0, 1'b0);
    n_checks++; if (in_ready !== 1'b1 || out_data !== 96'hA) $display("FAIL bp_first: got rdy=%b d=%h exp rdy=1 d=a", in_ready, out_data); else n_pass++;
    drive_cycle(1'b1, 1'b1, 96'hB, 2'b10, 1'b0, 1'b0);
    n_checks++; if (in_ready !== 1'b0) $display("FAIL bp_full_ready: got %b exp 0", in_ready); else n_pass++;
    n_checks++; if (dbg_state !== 2'b11) $display("FAIL bp_full_state: got %b exp 11", dbg_state); else n_pass++;
    drive_cycle(1'b1, 1'b1, 96'hC, 2'b11, 1'b0, 1'b0);
    n_checks++; if (in_ready !== 1'b0 || out_data !== 96'hA) $display("FAIL bp_held: got rdy=%b d=%h exp rdy=0 d=a", in_ready, out_data); else n_pass++;
    drive_cycle(1'b1, 1'b1, 96'hC, 2'b11, 1'b1, 1'b0);
    n_checks++; if (out_data !== 96'hB || out_sb !== 2'b10 || in_ready !== 1'b1) $display("FAIL bp_second: got d=%h sb=%b rdy=%b exp d=b sb=10 rdy=1", out_data, out_sb, in_ready); else n_pass++;
    drive_cycle(1'b1, 1'b1, 96'hC, 2'b11, 1'b1, 1'b0);
    n_checks++; if (out_data !== 96'hC || out_sb !== 2'b11) $display("FAIL bp_third: got d=%h sb=%b exp d=c sb=11", out_data, out_sb); else n_pass++;
    drive_cycle(1'b0, 1'b1, 'x, 2'b00, 1'b1, 1'b0);
    n_checks++; if (out_valid !== 1'b0) $display("FAIL bp_drained: got %b exp 0", out_valid); else n_pass++;
  endtask

  task automatic test_squash();
    drive_cycle(1'b1, 1'b0, 96'hDEAD, 2'b01, 1'b0, 1'b0);
    n_checks++; if (out_valid !== 1'b1) $display("FAIL squash_valid: got %b exp 1", out_valid); else n_pass++;
    n_checks++; if (out_data !== NOP) $display("FAIL squash_data: got %h exp %h", out_data, NOP); else n_pass++;
    n_checks++; if (out_sb !== 2'b01) $display("FAIL squash_sb: got %b exp 01", out_sb); else n_pass++;
    drive_cycle(1'b0, 1'b1, 'x, 2'b00, 1'b1, 1'b0);
    n_checks++; if (out_valid !== 1'b0) $display("FAIL squash_drained: got %b exp 0", out_valid); else n_pass++;
  endtask

  task automatic test_flush();
    drive_cycle(1'b1, 1'b1, 96'hF1, 2'b01, 1'b0, 1'b0);
    drive_cycle(1'b1, 1'b1, 96'hF2, 2'b10, 1'b0, 1'b0);
    n_checks++; if (dbg_state !== 2'b11) $display("FAIL flush_setup: got %b exp 11", dbg_state); else n_pass++;
    drive_cycle(1'b1, 1'b1, 96'hF3, 2'b11, 1'b0, 1'b1);
    n_checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) $display("FAIL flush_state: got v=%b rdy=%b exp v=0 rdy=1", out_valid, in_ready); else n_pass++;
    n_checks++; if (out_data !== NOP || out_sb !== 2'b00) $display("FAIL flush_outputs: got d=%h sb=%b exp d=%h sb=00", out_data, out_sb, NOP); else n_pass++;
    for (int i = 0; i < 3; i++) begin
      drive_cycle(1'b0, 1'b1, 'x, 2'b00, 1'b1, 1'b0);
      n_checks++; if (out_valid !== 1'b0) $display("FAIL flush_no_ghost_%0d: got v=%b d=%h exp v=0", i, out_valid, out_data); else n_pass++;
    end
  endtask

`ifdef PIPE_STAGE_PERF_CNT_EN
  task automatic test_perf();
    #3 rst = 1'b1;
    #1 rst = 1'b0;
    exp_q.delete(); nop_q.delete(); m_stall = 0; m_bubble = 0;
    drive_cycle(1'b1, 1'b1, 96'h55, 2'b00, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) drive_cycle(1'b0, 1'b1, 'x, 2'b00, 1'b0, 1'b0);
    n_checks++; if (stall_cnt !== 32'd5) $display("FAIL perf_stall5: got %0d exp 5", stall_cnt); else n_pass++;
    n_checks++; if (bubble_cnt !== 32'd1) $display("FAIL perf_bubble_load: got %0d exp 1", bubble_cnt); else n_pass++;
    drive_cycle(1'b0, 1'b1, 'x, 2'b00, 1'b1, 1'b0);
    drive_cycle(1'b0, 1'b1, 'x, 2'b00, 1'b1, 1'b0);
    drive_cycle(1'b0, 1'b1, 'x, 2'b00, 1'b1, 1'b0);
    n_checks++; if (stall_cnt !== 32'd5 || bubble_cnt !== 32'd3) $display("FAIL perf_idle2: got %0d/%0d exp 5/3", stall_cnt, bubble_cnt); else n_pass++;
    // fill, stall once, then flush: counters keep counting, not cleared
    drive_cycle(1'b1, 1'b1, 96'h66, 2'b00, 1'b0, 1'b0);
    drive_cycle(1'b0, 1'b1, 'x, 2'b00, 1'b0, 1'b1);
    n_checks++; if (stall_cnt !== 32'd6 || bubble_cnt !== 32'd4) $display("FAIL perf_flush: got %0d/%0d exp 6/4", stall_cnt, bubble_cnt); else n_pass++;
    // a drained NOP-substituted beat counts as a bubble
    drive_cycle(1'b1, 1'b0, 96'h77, 2'b00, 1'b0, 1'b0);
    drive_cycle(1'b0, 1'b1, 'x, 2'b00, 1'b1, 1'b0);
    n_checks++; if (stall_cnt !== 32'd6 || bubble_cnt !== 32'd6) $display("FAIL perf_nop_drain: got %0d/%0d exp 6/6", stall_cnt, bubble_cnt); else n_pass++;
  endtask
`endif

  task automatic test_random();
    logic [W+SB-1:0] head;
    logic            e_v;
    logic [W-1:0]    e_d;
    logic [SB-1:0]   e_sb;
    logic            v, pass, ordy, flsh;
    logic [W-1:0]    d;
    for (int i = 0; i < 400; i++) begin
      v    = ($urandom_range(0, 9) < 7);
      pass = ($urandom_range(0, 9) < 8);
      ordy = ($urandom_range(0, 9) < 6);
      flsh = ($urandom_range(0, 29) == 0);
      d    = v ? {$urandom, $urandom, $urandom} : 'x;
      drive_cycle(v, pass, d, SB'($urandom_range(0, 3)), ordy, flsh);
      e_v = (exp_q.size() > 0);
      head = e_v ? exp_q[0] : '0;
      e_d  = e_v ? head[W-1:0] : NOP;
      e_sb = e_v ? head[W+SB-1:W] : '0;
      n_checks++; if (out_valid !== e_v) $display("FAIL rand_valid @%0d: got %b exp %b", i, out_valid, e_v); else n_pass++;
      n_checks++; if (out_data !== e_d) $display("FAIL rand_data @%0d: got %h exp %h", i, out_data, e_d); else n_pass++;
      n_checks++; if (out_sb !== e_sb) $display("FAIL rand_sb @%0d: got %b exp %b", i, out_sb, e_sb); else n_pass++;
      n_checks++; if (in_ready !== (exp_q.size() < 2)) $display("FAIL rand_in_ready @%0d: got %b exp %b", i, in_ready, exp_q.size() < 2); else n_pass++;
      n_checks++; if (dbg_state !== {e_v, exp_q.size() == 2}) $display("FAIL rand_state @%0d: got %b exp %b%b", i, dbg_state, e_v, exp_q.size() == 2); else n_pass++;
`ifdef PIPE_STAGE_PERF_CNT_EN
      n_checks++; if (stall_cnt !== 32'(m_stall) || bubble_cnt !== 32'(m_bubble)) $display("FAIL rand_cnt @%0d: got %0d/%0d exp %0d/%0d", i, stall_cnt, bubble_cnt, m_stall, m_bubble); else n_pass++;
`endif
    end
  endtask

  initial begin
    test_reset();
    test_streaming();
    test_backpressure();
    test_squash();
    test_flush();
`ifdef PIPE_STAGE_PERF_CNT_EN
    test_perf();
`endif
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
